// File: rtl/gemm_dsp_pkg.sv
// Shared constants and types for the GEMM DSP sequencing logic.
// Holds the DSP48E2 OPMODE tags that the MAC sequencer drives, the fixed ALU and
// INMODE settings, and the MAC sequencer state encoding.
package gemm_dsp_pkg;

    // OPMODE tags: Z mux in bits [6:4], X/Y muxes in bits [3:0]
    localparam logic [8:0] OPMODE_LOAD = 9'b00_000_0101;  // P = M
    localparam logic [8:0] OPMODE_ACC  = 9'b00_010_0101;  // P = P + M
    localparam logic [8:0] OPMODE_HOLD = 9'b00_010_0000;  // P = P + 0
    localparam logic [8:0] OPMODE_ZERO = 9'b0_0000_0000;  // P = 0

    localparam logic [3:0] ALUMODE_ADD = 4'b0000;         // Z + X + Y + CIN
    localparam logic [4:0] INMODE_A2B2 = 5'b00000;        // multiplier uses A2 x B2

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

endpackage

// File: rtl/dsp_mac_tagline.sv
// OPMODE tag delay line for the MAC sequencer.
// Delays each pushed tag by DEPTH cycles so it reaches the DSP in the same cycle
// as the product it belongs to. Unlike flt_delay it has an async reset to ZERO and
// a synchronous flush, so the DSP never sees a stale LOAD/ACC after a reset or abort.
module dsp_mac_tagline
    import gemm_dsp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic [8:0] i_tag,
    output logic [8:0] o_tag
);

    logic [8:0] r_line [DEPTH];

    // Shift one tag per cycle; reset and flush clear every stage to ZERO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= OPMODE_ZERO;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) r_line[i] <= OPMODE_ZERO;
        end else begin
            r_line[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
        end
    end

    assign o_tag = r_line[DEPTH-1];

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Multiply-accumulate sequencer for one dsp48e2 wrapper instance.
// Accepts a job of k_len operand pairs, streams them into the DSP with OPMODE tags
// aligned to the DSP pipeline (first product loads P, later ones accumulate, bubbles
// hold), drains the pipeline and returns the dot product on a valid/ready port.
// Optional macro DSP_MAC_CTRL_ABORT_EN adds an 'abort' input that cancels a job.
module dsp_mac_ctrl
    import gemm_dsp_pkg::*;
#(
    parameter int DATA_A_W   = 16,
    parameter int DATA_B_W   = 16,
    parameter int ACC_W      = 48,
    parameter int K_W        = 16,
    parameter int CTRL_DELAY = 2,
    parameter int PIPE_LAT   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DSP_MAC_CTRL_ABORT_EN
    input  logic                abort,
`endif
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_A_W-1:0] in_a,
    input  logic [DATA_B_W-1:0] in_b,
    output logic [DATA_A_W-1:0] dsp_a,
    output logic [DATA_B_W-1:0] dsp_b,
    output logic                dsp_ce,
    output logic [8:0]          dsp_op_mode,
    output logic [3:0]          dsp_alu_mode,
    output logic [4:0]          dsp_in_mode,
    input  logic [ACC_W-1:0]    dsp_p,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data
);

    localparam int DCNT_W = $clog2(PIPE_LAT + 1);

    mac_state_e        r_state;
    logic [K_W-1:0]    r_rem;
    logic              r_first;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_resValid;
    logic [ACC_W-1:0]  r_resData;

    logic              w_fire;
    logic              w_abort;
    logic [8:0]        w_tagIn;

`ifdef DSP_MAC_CTRL_ABORT_EN
    assign w_abort = abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign in_ready     = (r_state == ST_FEED);
    assign busy         = (r_state != ST_IDLE);
    assign w_fire       = in_valid && in_ready;
    assign dsp_a        = in_a;
    assign dsp_b        = in_b;
    assign dsp_ce       = rst_n;
    assign dsp_alu_mode = ALUMODE_ADD;
    assign dsp_in_mode  = INMODE_A2B2;
    assign res_valid    = r_resValid;
    assign res_data     = r_resData;

    // Tag for the operand pair presented this cycle; anything that is not a fire holds P
    always_comb begin
        w_tagIn = OPMODE_HOLD;
        if (w_fire) begin
            w_tagIn = r_first ? OPMODE_LOAD : OPMODE_ACC;
        end
    end

    // Delays tags by the operand register depth so they meet their product at the P stage
    dsp_mac_tagline #(
        .DEPTH (CTRL_DELAY)
    ) u_tagline (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_tag   (w_tagIn),
        .o_tag   (dsp_op_mode)
    );

    // Job sequencer: the drain counter is loaded with PIPE_LAT and the capture happens on the
    // edge where it reaches zero, which is exactly when the last product has settled in P
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_first    <= 1'b0;
            r_dcnt     <= '0;
            r_resValid <= 1'b0;
            r_resData  <= '0;
        end else if (w_abort) begin
            r_state    <= ST_IDLE;
            r_resValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (k_len != '0)) begin
                        r_rem   <= k_len;
                        r_first <= 1'b1;
                        r_state <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (w_fire) begin
                        r_first <= 1'b0;
                        r_rem   <= r_rem - K_W'(1);
                        if (r_rem == K_W'(1)) begin
                            r_dcnt  <= DCNT_W'(PIPE_LAT);
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_dcnt <= r_dcnt - DCNT_W'(1);
                    if (r_dcnt == DCNT_W'(1)) begin
                        r_resData  <= dsp_p;
                        r_resValid <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Self-checking bench for dsp_mac_ctrl.
// Includes a behavioural dsp48e2 stand-in (A/B reg, M reg, P reg driven by OPMODE) and
// checks results against dot products computed directly from the operand lists.
// Build with DSP_MAC_CTRL_ABORT_EN defined to also exercise the abort input.
module tb_dsp_mac_ctrl;

    localparam int PIPE_LAT = 3;
    localparam int CTRL_DELAY = 2;
    localparam logic [8:0] T_LOAD = 9'b00_000_0101;
    localparam logic [8:0] T_ACC  = 9'b00_010_0101;
    localparam logic [8:0] T_HOLD = 9'b00_010_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] k_len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] dsp_a;
    logic [15:0] dsp_b;
    logic        dsp_ce;
    logic [8:0]  dsp_op_mode;
    logic [3:0]  dsp_alu_mode;
    logic [4:0]  dsp_in_mode;
    logic [47:0] dsp_p;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
`ifdef DSP_MAC_CTRL_ABORT_EN
    logic        abort = 1'b0;
`endif

    int checkCount = 0;
    int failCount = 0;
    int cyc = 0;

    logic [15:0] jobA [16];
    logic [15:0] jobB [16];
    logic [8:0]  expTag [int];

    // DSP48E2 stand-in
    logic [15:0] mA = '0;
    logic [15:0] mB = '0;
    logic [47:0] mM = '0;
    logic [47:0] mP = '0;

    dsp_mac_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DSP_MAC_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_ce       (dsp_ce),
        .dsp_op_mode  (dsp_op_mode),
        .dsp_alu_mode (dsp_alu_mode),
        .dsp_in_mode  (dsp_in_mode),
        .dsp_p        (dsp_p),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    always #5 clk = ~clk;

    // Cycle counter, cycle n runs from posedge n to posedge n+1
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural wrapper: operands registered, product registered, P updated by OPMODE
    always @(posedge clk) begin
        if (dsp_ce) begin
            mA <= dsp_a;
            mB <= dsp_b;
            mM <= 48'(mA) * 48'(mB);
            case (dsp_op_mode)
                T_LOAD:  mP <= mM;
                T_ACC:   mP <= mP + mM;
                9'd0:    mP <= '0;
                default: mP <= mP;
            endcase
        end
    end
    assign dsp_p = mP;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Each recorded per-cycle tag must show up on dsp_op_mode CTRL_DELAY cycles later
    always @(negedge clk) begin
        if (rst_n && expTag.exists(cyc - CTRL_DELAY)) begin
            checkOutput("opModeTrace", 64'(dsp_op_mode), 64'(expTag[cyc - CTRL_DELAY]));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from jobA/jobB; gap<0 picks random bubbles, rrDelay=0 means res_ready tied high
    task automatic applyStimulus(input int k, input int gap, input int rrDelay, output int startCyc);
        logic [47:0] expSum;
        int lastFire;
        int waitCnt;
        int nb;
        expSum = '0;
        for (int i = 0; i < k; i++) expSum = expSum + 48'(jobA[i]) * 48'(jobB[i]);
        start = 1'b1;
        k_len = 16'(k);
        res_ready = (rrDelay == 0);
        startCyc = cyc;
        @(negedge clk);
        checkOutput("busyIdle", 64'(busy), 64'd0);
        stepCycle();
        start = 1'b0;
        lastFire = cyc;
        for (int i = 0; i < k; i++) begin
            nb = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            for (int j = 0; j < nb; j++) begin
                in_valid = 1'b0;
                in_a = 16'($urandom);
                in_b = 16'($urandom);
                @(negedge clk);
                checkOutput("inReadyBubble", 64'(in_ready), 64'd1);
                expTag[cyc] = T_HOLD;
                stepCycle();
            end
            in_valid = 1'b1;
            in_a = jobA[i];
            in_b = jobB[i];
            @(negedge clk);
            checkOutput("inReadyFire", 64'(in_ready), 64'd1);
            checkOutput("busyFeed", 64'(busy), 64'd1);
            checkOutput("dspAPass", 64'(dsp_a), 64'(jobA[i]));
            expTag[cyc] = (i == 0) ? T_LOAD : T_ACC;
            lastFire = cyc;
            stepCycle();
        end
        in_valid = 1'b0;
        for (int d = 1; d <= PIPE_LAT; d++) expTag[lastFire + d] = T_HOLD;
        @(negedge clk);
        checkOutput("inReadyDrain", 64'(in_ready), 64'd0);
        waitCnt = 0;
        while (!res_valid && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("resValidRise", 64'(res_valid), 64'd1);
        checkOutput("resLatency", 64'(cyc - lastFire), 64'(PIPE_LAT + 1));
        checkOutput("resData", 64'(res_data), 64'(expSum));
        if (rrDelay > 0) begin
            for (int j = 1; j <= rrDelay; j++) begin
                stepCycle();
                start = (j == 2);
                k_len = 16'd3;
                @(negedge clk);
                checkOutput("resValidHeld", 64'(res_valid), 64'd1);
                checkOutput("resDataHeld", 64'(res_data), 64'(expSum));
            end
            stepCycle();
            start = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            checkOutput("resValidPreHs", 64'(res_valid), 64'd1);
            stepCycle();
            @(negedge clk);
            checkOutput("busyAfterHs", 64'(busy), 64'd0);
            checkOutput("resValidAfterHs", 64'(res_valid), 64'd0);
        end
        stepCycle();
    endtask

    initial begin
        int s1;
        int s2;
        int kk;
        #200000;
        $display("[TB] FAIL globalTimeout: got timeout, expected completion");
        $fatal(1, "[TB] stopping");
    end

    initial begin
        int s1;
        int s2;
        int kk;
        int waitCnt;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstInReady", 64'(in_ready), 64'd0);
        checkOutput("rstResValid", 64'(res_valid), 64'd0);
        checkOutput("rstResData", 64'(res_data), 64'd0);
        checkOutput("rstOpMode", 64'(dsp_op_mode), 64'd0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        @(negedge clk);
        checkOutput("ceOn", 64'(dsp_ce), 64'd1);
        checkOutput("aluMode", 64'(dsp_alu_mode), 64'd0);
        checkOutput("inMode", 64'(dsp_in_mode), 64'd0);
        stepCycle();

        // k=4 back-to-back: 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin
            jobA[i] = 16'(i + 1);
            jobB[i] = 16'(i + 5);
        end
        applyStimulus(4, 0, 0, s1);

        // k=3 with two-cycle bubbles: 20+30+40 = 90
        jobA[0] = 16'd2; jobA[1] = 16'd3; jobA[2] = 16'd4;
        for (int i = 0; i < 3; i++) jobB[i] = 16'd10;
        applyStimulus(3, 2, 0, s1);
        repeat (2) stepCycle();

        // Back-to-back jobs with res_ready high: 42 then 2 at minimum spacing
        jobA[0] = 16'd7; jobB[0] = 16'd6;
        applyStimulus(1, 0, 0, s1);
        jobA[0] = 16'd1; jobB[0] = 16'd1; jobA[1] = 16'd1; jobB[1] = 16'd1;
        applyStimulus(2, 0, 0, s2);
        checkOutput("startSpacing", 64'(s2 - s1), 64'(1 + PIPE_LAT + 2));

        // Back-pressure with start pulsed during OUT
        jobA[0] = 16'hFFFF; jobB[0] = 16'hFFFF; jobA[1] = 16'd3; jobB[1] = 16'd9;
        applyStimulus(2, 0, 5, s1);

        // start with k_len=0 is ignored
        start = 1'b1;
        k_len = 16'd0;
        stepCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("kZeroBusy", 64'(busy), 64'd0);
        checkOutput("kZeroInReady", 64'(in_ready), 64'd0);
        stepCycle();

        // Reset during the 2nd beat of a k=4 job
        start = 1'b1;
        k_len = 16'd4;
        stepCycle();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 16'd5;
        in_b = 16'd5;
        stepCycle();
        in_a = 16'd6;
        rst_n = 1'b0;
        expTag.delete();
        @(negedge clk);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstInReady", 64'(in_ready), 64'd0);
        checkOutput("midRstResValid", 64'(res_valid), 64'd0);
        checkOutput("midRstResData", 64'(res_data), 64'd0);
        checkOutput("midRstOpMode", 64'(dsp_op_mode), 64'd0);
        stepCycle();
        in_valid = 1'b0;
        rst_n = 1'b1;
        stepCycle();
        jobA[0] = 16'd3; jobB[0] = 16'd3;
        applyStimulus(1, 0, 0, s1);

`ifdef DSP_MAC_CTRL_ABORT_EN
        // Abort during DRAIN: no result, tags flushed
        start = 1'b1;
        k_len = 16'd2;
        stepCycle();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 16'd9; in_b = 16'd9;
        stepCycle();
        stepCycle();
        in_valid = 1'b0;
        abort = 1'b1;
        expTag.delete();
        stepCycle();
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortOpMode", 64'(dsp_op_mode), 64'd0);
        waitCnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) waitCnt++;
            @(negedge clk);
        end
        checkOutput("abortNoResult", 64'(waitCnt), 64'd0);
        stepCycle();
        jobA[0] = 16'd4; jobB[0] = 16'd4; jobA[1] = 16'd1; jobB[1] = 16'd2;
        applyStimulus(2, 0, 0, s1);
`endif

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            kk = int'($urandom_range(1, 8));
            for (int i = 0; i < kk; i++) begin
                jobA[i] = 16'($urandom);
                jobB[i] = 16'($urandom);
            end
            applyStimulus(kk, -1, int'($urandom_range(0, 3)), s1);
        end

        repeat (4) stepCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
